// File: rtl/dmi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmi_arbiter_if
// Description : Bundles the per-master DMI request/response channels and the
//               single DMI port towards the debug module.
//               slave  - arbiter side (takes master requests, drives the DM)
//               master - environment side (masters plus debug module)
//               Ports: req_i/req_valid_i/req_ready_o (per-master request),
//               resp_o/resp_valid_o/resp_ready_i (per-master response),
//               dmi_req_o/dmi_req_valid_o/dmi_req_ready_i (request to DM),
//               dmi_resp_i/dmi_resp_valid_i/dmi_resp_ready_o (DM response).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmi_arbiter_if #(
  parameter int NumReq = 2
);
  // Request payload layout: {addr[6:0], data[31:0], op[1:0]}
  logic [NumReq-1:0][40:0] req_i;
  logic [NumReq-1:0]       req_valid_i;
  logic [NumReq-1:0]       req_ready_o;
  // Response payload layout: {data[31:0], resp[1:0]}
  logic [33:0]             resp_o;
  logic [NumReq-1:0]       resp_valid_o;
  logic [NumReq-1:0]       resp_ready_i;
  logic [40:0]             dmi_req_o;
  logic                    dmi_req_valid_o;
  logic                    dmi_req_ready_i;
  logic [33:0]             dmi_resp_i;
  logic                    dmi_resp_valid_i;
  logic                    dmi_resp_ready_o;

  modport slave (
    input  req_i, req_valid_i, resp_ready_i,
    input  dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    output req_ready_o, resp_o, resp_valid_o,
    output dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );

  modport master (
    output req_i, req_valid_i, resp_ready_i,
    output dmi_req_ready_i, dmi_resp_i, dmi_resp_valid_i,
    input  req_ready_o, resp_o, resp_valid_o,
    input  dmi_req_o, dmi_req_valid_o, dmi_resp_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmi_arbiter
// Description : Round-robin arbiter sharing the DM's single DMI port between
//               NumReq masters, one transaction in flight. The DM response
//               is passed straight through to the master that issued the
//               request; a watchdog answers DTM_ERR if the DM stays silent.
//               Ports: clk_i (DM clock), rst_i (sync, active-high),
//               bus (dmi_arbiter_if.slave, all handshake/payload signals).
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_arbiter #(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmi_arbiter_if.slave  bus
);

  localparam int c_owner_w = $clog2(NumReq);
  localparam int c_timer_w = $clog2(TimeoutCycles) + 1;
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TimeoutCycles - 1);
  localparam logic [c_owner_w-1:0] c_owner_last = c_owner_w'(NumReq - 1);
  localparam logic [c_owner_w:0]   c_num_req    = (c_owner_w + 1)'(NumReq);
  localparam logic [1:0]           c_dtm_err    = 2'h2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_ERR   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                 r_state,   w_state_nxt;
  logic [c_owner_w-1:0]   r_owner,   w_owner_nxt;
  logic [c_owner_w-1:0]   r_rr_ptr,  w_rr_nxt;
  logic [c_timer_w-1:0]   r_timer,   w_timer_nxt;
  logic [40:0]            r_payload, w_payload_nxt;
  logic [c_timer_w-1:0]   w_timer_inc;

  logic                   w_found;
  logic [c_owner_w-1:0]   w_winner;
  logic [c_owner_w-1:0]   w_idx;
  logic [c_owner_w:0]     w_sum;

  logic [NumReq-1:0]      w_req_ready;
  logic [NumReq-1:0]      w_resp_valid;
  logic [33:0]            w_resp;
  logic [40:0]            w_dmi_req;
  logic                   w_dmi_req_valid;
  logic                   w_dmi_resp_ready;

  // Round-robin pick: first valid master at or after rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    w_sum    = '0;
    for (int k = 0; k < NumReq; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_owner_w + 1)'(k);
      if (w_sum >= c_num_req) w_sum = w_sum - c_num_req;
      w_idx = w_sum[c_owner_w-1:0];
      if (!w_found && bus.req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  // Saturating increment so the watchdog can never wrap back to zero.
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_rr_nxt         = r_rr_ptr;
    w_timer_nxt      = r_timer;
    w_payload_nxt    = r_payload;
    w_req_ready      = '0;
    w_resp_valid     = '0;
    w_resp           = '0;
    w_dmi_req        = '0;
    w_dmi_req_valid  = 1'b0;
    w_dmi_resp_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Ready follows valid combinationally, so a winner means a handshake.
        if (w_found) begin
          w_req_ready[w_winner] = 1'b1;
          w_payload_nxt         = bus.req_i[w_winner];
          w_owner_nxt           = w_winner;
          w_rr_nxt              = (w_winner == c_owner_last) ? '0 : w_winner + 1'b1;
          w_state_nxt           = S_REQ;
        end
      end
      S_REQ: begin
        w_dmi_req_valid = 1'b1;
        w_dmi_req       = r_payload;
        if (bus.dmi_req_ready_i) begin
          w_timer_nxt = '0;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_resp                = bus.dmi_resp_i;
        w_resp_valid[r_owner] = bus.dmi_resp_valid_i;
        w_dmi_resp_ready      = bus.resp_ready_i[r_owner];
        if (bus.dmi_resp_valid_i) begin
          // A response stalled by the master freezes the watchdog.
          if (bus.resp_ready_i[r_owner]) w_state_nxt = S_IDLE;
        end else if (r_timer == c_timer_last) begin
          w_state_nxt = S_ERR;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      S_ERR: begin
        w_resp                = {32'h0, c_dtm_err};
        w_resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready_i[r_owner]) begin
          w_timer_nxt = '0;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Swallow at most one late DM answer so it never reaches a master.
        w_dmi_resp_ready = 1'b1;
        if (bus.dmi_resp_valid_i || (r_timer == c_timer_last)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_timer   <= '0;
      r_payload <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_timer   <= w_timer_nxt;
      r_payload <= w_payload_nxt;
    end
  end

  // Outputs are forced low while reset is asserted so no grant or response
  // escapes during reset, even though IDLE's grant is combinational.
  assign bus.req_ready_o      = rst_i ? '0   : w_req_ready;
  assign bus.resp_valid_o     = rst_i ? '0   : w_resp_valid;
  assign bus.resp_o           = rst_i ? '0   : w_resp;
  assign bus.dmi_req_o        = rst_i ? '0   : w_dmi_req;
  assign bus.dmi_req_valid_o  = rst_i ? 1'b0 : w_dmi_req_valid;
  assign bus.dmi_resp_ready_o = rst_i ? 1'b0 : w_dmi_resp_ready;

endmodule
`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_arbiter
// Description : Directed self-checking bench for dmi_arbiter (NumReq=2,
//               TimeoutCycles=8): reset, fairness, routing, backpressure,
//               watchdog/drain and mid-transaction reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_arbiter;

  localparam int N  = 2;
  localparam int TO = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  dmi_arbiter_if #(.NumReq(N)) bus ();

  dmi_arbiter #(.NumReq(N), .TimeoutCycles(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [40:0] pl [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // One full transaction from IDLE: grant g, DM accepts at once, answers rsp.
  task automatic txn(input int g, input logic [33:0] rsp);
    chk("grant", 64'(bus.req_ready_o), 64'(1) << g);
    bus.dmi_req_ready_i = 1'b1;
    tick();
    chk("dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'(1));
    chk("dmi_req_payload", 64'(bus.dmi_req_o), 64'(pl[g]));
    tick();
    bus.dmi_resp_i       = rsp;
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    chk("resp_valid_route", 64'(bus.resp_valid_o), 64'(1) << g);
    chk("resp_data", 64'(bus.resp_o), 64'(rsp));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    pl[0] = {7'h01, 32'h1111_2222, 2'h2};
    pl[1] = {7'h11, 32'h0000_0000, 2'h1};
    bus.req_i            = '0;
    bus.req_i[0]         = pl[0];
    bus.req_i[1]         = pl[1];
    bus.req_valid_i      = 2'b11;
    bus.resp_ready_i     = 2'b11;
    bus.dmi_req_ready_i  = 1'b0;
    bus.dmi_resp_i       = '0;
    bus.dmi_resp_valid_i = 1'b0;

    // Reset held two cycles with every master requesting.
    rst_i = 1'b1;
    tick();
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'(0));
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_dmi_req_valid", 64'(bus.dmi_req_valid_o), 64'(0));
    chk("rst_dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'(0));
    chk("rst_dmi_req", 64'(bus.dmi_req_o), 64'(0));
    chk("rst_resp", 64'(bus.resp_o), 64'(0));
    tick();
    chk("rst_req_ready_2", 64'(bus.req_ready_o), 64'(0));
    rst_i = 1'b0;
    #1;

    // Fairness and routing: alternating grants, m1 read of 0x11.
    txn(0, {32'h0000_00A5, 2'h0});
    txn(1, {32'hCAFE_F00D, 2'h0});
    txn(0, {32'h1234_5678, 2'h0});
    txn(1, {32'h8765_4321, 2'h3});

    // Backpressure on the DM request side: payload held, no new grant.
    chk("bp_grant", 64'(bus.req_ready_o), 64'(1));
    bus.dmi_req_ready_i = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_stable", 64'(bus.dmi_req_o), 64'(pl[0]));
      chk("bp_req_valid", 64'(bus.dmi_req_valid_o), 64'(1));
      chk("bp_no_grant", 64'(bus.req_ready_o), 64'(0));
      tick();
    end
    bus.dmi_req_ready_i = 1'b1;
    bus.resp_ready_i    = 2'b00;
    tick();
    // RESP: 3 silent cycles (timer 0..2 -> 3).
    for (int i = 0; i < 3; i++) begin
      chk("bp_silent_valid", 64'(bus.resp_valid_o), 64'(0));
      chk("bp_silent_ready", 64'(bus.dmi_resp_ready_o), 64'(0));
      tick();
    end
    // Response valid but stalled by master: timer must hold at 3.
    bus.dmi_resp_i       = {32'hDEAD_BEEF, 2'h0};
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_resp_valid", 64'(bus.resp_valid_o), 64'(1));
      chk("stall_dmi_resp_ready", 64'(bus.dmi_resp_ready_o), 64'(0));
      chk("stall_resp_data", 64'(bus.resp_o), 64'({32'hDEAD_BEEF, 2'h0}));
      tick();
    end
    // DM withdraws; five more silent cycles (timer 3..7) before error.
    bus.dmi_resp_valid_i = 1'b0;
    bus.resp_ready_i     = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_silent_valid", 64'(bus.resp_valid_o), 64'(0));
      tick();
    end
    chk("bp_err_valid", 64'(bus.resp_valid_o), 64'(1));
    chk("bp_err_resp", 64'(bus.resp_o), 64'(2));
    chk("bp_err_dmi_ready", 64'(bus.dmi_resp_ready_o), 64'(0));
    tick();
    // DRAIN: late response sunk, not forwarded.
    bus.dmi_resp_i       = {32'h5555_AAAA, 2'h0};
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    chk("drain_dmi_ready", 64'(bus.dmi_resp_ready_o), 64'(1));
    chk("drain_no_fwd", 64'(bus.resp_valid_o), 64'(0));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    #1;
    chk("post_drain_grant", 64'(bus.req_ready_o), 64'(2));

    // Pure timeout on m1: 8 silent RESP cycles, then DTM_ERR.
    tick();
    tick();
    for (int i = 0; i < TO; i++) begin
      chk("to_silent_valid", 64'(bus.resp_valid_o), 64'(0));
      tick();
    end
    chk("to_err_valid", 64'(bus.resp_valid_o), 64'(2));
    chk("to_err_resp", 64'(bus.resp_o), 64'(2));
    tick();
    // DRAIN with no late answer expires after TO cycles.
    for (int i = 0; i < TO; i++) begin
      chk("to_drain_ready", 64'(bus.dmi_resp_ready_o), 64'(1));
      tick();
    end
    chk("to_idle_dmi_ready", 64'(bus.dmi_resp_ready_o), 64'(0));

    // Spurious DM response in IDLE is ignored.
    bus.req_valid_i      = 2'b00;
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    chk("spur_no_fwd", 64'(bus.resp_valid_o), 64'(0));
    chk("spur_no_ack", 64'(bus.dmi_resp_ready_o), 64'(0));
    tick();
    bus.dmi_resp_valid_i = 1'b0;
    bus.req_valid_i      = 2'b11;
    #1;
    txn(0, {32'h0BAD_F00D, 2'h0});

    // rr_ptr=1, only m0 requesting: wrap-around grant to m0.
    bus.req_valid_i = 2'b01;
    #1;
    chk("wrap_grant", 64'(bus.req_ready_o), 64'(1));
    tick();
    tick();
    // In RESP: reset aborts the transaction.
    rst_i = 1'b1;
    bus.dmi_resp_i       = {32'h7777_7777, 2'h0};
    bus.dmi_resp_valid_i = 1'b1;
    #1;
    chk("rst_resp_no_valid", 64'(bus.resp_valid_o), 64'(0));
    tick();
    rst_i           = 1'b0;
    bus.req_valid_i = 2'b11;
    #1;
    chk("rst_abort_no_resp", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_rr_ptr_zero", 64'(bus.req_ready_o), 64'(1));
    bus.dmi_resp_valid_i = 1'b0;
    tick();
    chk("post_rst_req", 64'(bus.dmi_req_o), 64'(pl[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
